// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared FSM state encoding, funct encodings and default width
//               for the iterative integer divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int c_width_def = 32;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_fix  = 2'd2;

  localparam logic [1:0] c_fn_div  = 2'b00;
  localparam logic [1:0] c_fn_divu = 2'b01;
  localparam logic [1:0] c_fn_rem  = 2'b10;
  localparam logic [1:0] c_fn_remu = 2'b11;

  function automatic logic fn_is_signed(input logic [1:0] f);
    return (f == c_fn_div) || (f == c_fn_rem);
  endfunction

  function automatic logic fn_is_rem(input logic [1:0] f);
    return (f == c_fn_rem) || (f == c_fn_remu);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_add_sub.sv
// ============================================================================
// Module      : CLA_ADD_SUB
// Description : Carry-lookahead adder/subtractor (4-bit lookahead groups).
//               OVF reports carry-out when adding and borrow when subtracting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module CLA_ADD_SUB #(
  parameter int WIDTH = 32
) (
  input  logic             En,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             OVF
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;

  assign w_b_eff = B ^ {WIDTH{SUB}};
  assign w_g     = A & w_b_eff;
  assign w_p     = A ^ w_b_eff;

  // Bit carries inside a group, plus group generate/propagate for the group carry-out.
  always_comb begin : p_carry
    logic [WIDTH:0] v_c;
    logic           v_gg;
    logic           v_gp;
    v_c    = '0;
    v_c[0] = SUB;
    v_gg   = 1'b0;
    v_gp   = 1'b1;
    for (int k = 0; k < WIDTH; k += 4) begin
      v_gg = 1'b0;
      v_gp = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (k + j < WIDTH) begin
          v_c[k+j+1] = w_g[k+j] | (w_p[k+j] & v_c[k+j]);
          v_gg       = w_g[k+j] | (w_p[k+j] & v_gg);
          v_gp       = v_gp & w_p[k+j];
        end
      end
      v_c[(k + 4 < WIDTH) ? k + 4 : WIDTH] = v_gg | (v_gp & v_c[k]);
    end
    w_c = v_c;
  end

  assign S   = En ? (w_p ^ w_c[WIDTH-1:0]) : '0;
  assign OVF = En & (SUB ? ~w_c[WIDTH] : w_c[WIDTH]);

endmodule

`default_nettype wire

// File: rtl/int_div_unit.sv
// ============================================================================
// Module      : int_div_unit
// Description : Iterative restoring divider (DIV/DIVU/REM/REMU), one quotient
//               bit per cycle. Optional macro DIV_EARLY_OUT_EN lets divide-by-
//               zero and signed overflow skip the iteration phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = c_width_def
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             En,
  input  logic [1:0]       funct,
  input  logic [WIDTH-1:0] rs_1,
  input  logic [WIDTH-1:0] rs_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_funct;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_dbz;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_div;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_dbz_out;

  logic             w_signed;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_zero_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_quot_final;
  logic [WIDTH-1:0] w_res_final;

  assign w_signed = fn_is_signed(funct);
  assign w_sign_a = w_signed & rs_1[WIDTH-1];
  assign w_sign_b = w_signed & rs_2[WIDTH-1];
  assign w_mag_a  = w_sign_a ? (~rs_1 + 1'b1) : rs_1;
  assign w_mag_b  = w_sign_b ? (~rs_2 + 1'b1) : rs_2;
  assign w_zero_b = (rs_2 == '0);

`ifdef DIV_EARLY_OUT_EN
  logic w_ovf;
  assign w_ovf = w_signed && (rs_1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&rs_2);
`endif

  // Extra remainder bit keeps the shifted partial remainder intact before the trial subtract.
  assign w_shift = (r_rem << 1) | {{WIDTH{1'b0}}, r_quot[WIDTH-1]};

  CLA_ADD_SUB #(
    .WIDTH (WIDTH + 1)
  ) u_trial_sub (
    .En  (1'b1),
    .SUB (1'b1),
    .A   (w_shift),
    .B   ({1'b0, r_div}),
    .S   (w_diff),
    .OVF (w_borrow)
  );

  assign w_quot_fix   = (r_sign_a ^ r_sign_b) ? (~r_quot + 1'b1) : r_quot;
  assign w_rem_fix    = r_sign_a ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
  assign w_quot_final = r_dbz ? {WIDTH{1'b1}} : w_quot_fix;
  assign w_res_final  = fn_is_rem(r_funct) ? w_rem_fix : w_quot_final;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_cnt     <= '0;
      r_funct   <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_dbz     <= 1'b0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_div     <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_dbz_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (En) begin
            r_funct  <= funct;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_dbz    <= w_zero_b;
            r_quot   <= w_mag_a;
            r_div    <= w_mag_b;
            r_cnt    <= CNT_W'(WIDTH - 1);
`ifdef DIV_EARLY_OUT_EN
            // Skipped iterations would leave |rs_1| as remainder for a zero divisor.
            if (w_zero_b || w_ovf) begin
              r_rem   <= w_zero_b ? {1'b0, w_mag_a} : '0;
              r_state <= c_st_fix;
            end else begin
              r_rem   <= '0;
              r_state <= c_st_calc;
            end
`else
            r_rem    <= '0;
            r_state  <= c_st_calc;
`endif
          end
        end
        c_st_calc: begin
          r_rem  <= w_borrow ? w_shift : w_diff;
          r_quot <= {r_quot[WIDTH-2:0], ~w_borrow};
          if (r_cnt == '0) begin
            r_state <= c_st_fix;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        c_st_fix: begin
          r_result  <= w_res_final;
          r_dbz_out <= r_dbz;
          r_done    <= 1'b1;
          r_state   <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign busy        = (r_state != c_st_idle);
  assign done        = r_done;
  assign result      = r_result;
  assign div_by_zero = r_dbz_out;

endmodule

`default_nettype wire

// File: tb/tb_int_div_unit.sv
// ============================================================================
// Module      : tb_int_div_unit
// Description : Directed self-checking bench for int_div_unit with a
//               cycle-level reference model (honours DIV_EARLY_OUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int LAT   = 33;
  localparam int LZ    = EARLY ? 1 : 33;

  logic        CLK   = 1'b0;
  logic        rst_n = 1'b1;
  logic        En    = 1'b0;
  logic [1:0]  funct = 2'b00;
  logic [31:0] rs_1  = '0;
  logic [31:0] rs_2  = '0;
  wire         busy;
  wire         done;
  wire  [31:0] result;
  wire         div_by_zero;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int_div_unit #(.WIDTH(32)) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .En          (En),
    .funct       (funct),
    .rs_1        (rs_1),
    .rs_2        (rs_2),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 CLK = ~CLK;

  function automatic logic is_signed_op(input logic [1:0] f);
    return (f == 2'b00) || (f == 2'b10);
  endfunction

  function automatic logic is_ovf(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    return is_signed_op(f) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 0)             return f[1] ? a : 32'hFFFF_FFFF;
    if (is_ovf(f, a, b))    return f[1] ? 32'h0 : a;
    if (is_signed_op(f))    return f[1] ? 32'(sa % sb) : 32'(sa / sb);
    return f[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    return (EARLY && ((b == 0) || is_ovf(f, a, b))) ? 1 : LAT;
  endfunction

  // Reference model: edge-numbered schedule of the single in-flight operation.
  logic        m_pend = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_res  = '0;
  logic        m_dbz  = 1'b0;
  logic [31:0] m_pres = '0;
  logic        m_pdbz = 1'b0;
  int          m_edge = 0;
  int          m_due  = 0;

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_dbz  <= 1'b0;
    end else begin
      m_edge <= m_edge + 1;
      m_done <= 1'b0;
      if (m_pend && (m_due == m_edge + 1)) begin
        m_pend <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pres;
        m_dbz  <= m_pdbz;
      end else if (!m_pend && En) begin
        m_pend <= 1'b1;
        m_pres <= ref_result(funct, rs_1, rs_2);
        m_pdbz <= (rs_2 == 0);
        m_due  <= m_edge + 1 + ref_lat(funct, rs_1, rs_2);
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      checks++;
      if (busy !== m_pend || done !== m_done || result !== m_res || div_by_zero !== m_dbz) begin
        errors++;
        $display("FAIL model t=%0t: busy %b want %b, done %b want %b, result %h want %h, dbz %b want %b",
                 $time, busy, m_pend, done, m_done, result, m_res, div_by_zero, m_dbz);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives the request now, holds it through one edge, then scrambles operands.
  task automatic start(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    En    = 1'b1;
    funct = f;
    rs_1  = a;
    rs_2  = b;
    @(posedge CLK);
    #1;
    En    = 1'b0;
    funct = ~f;
    rs_1  = ~a ^ 32'h5A5A_5A5A;
    rs_2  = b + 32'd3;
  endtask

  task automatic wait_done(input string nm, input logic [31:0] er, input logic ez, input int elat);
    int n;
    n = 0;
    while (n < 40) begin
      @(posedge CLK);
      n++;
      #1;
      if (done === 1'b1) break;
    end
    check({nm, " latency"}, n, elat);
    check({nm, " result"}, result, er);
    check({nm, " dbz"}, {31'b0, div_by_zero}, {31'b0, ez});
  endtask

  task automatic run_op(input string nm, input logic [1:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ez, input int elat);
    @(negedge CLK);
    start(f, a, b);
    wait_done(nm, er, ez, elat);
  endtask

  initial begin
    int n;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset busy",   {31'b0, busy},        32'd0);
    check("reset done",   {31'b0, done},        32'd0);
    check("reset result", result,               32'd0);
    check("reset dbz",    {31'b0, div_by_zero}, 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op("divu 100/7",  2'b01, 32'd100,        32'd7,          32'd14,         1'b0, LAT);
    run_op("remu 100/7",  2'b11, 32'd100,        32'd7,          32'd2,          1'b0, LAT);
    run_op("div -20/3",   2'b00, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA,  1'b0, LAT);
    run_op("rem -20/3",   2'b10, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE,  1'b0, LAT);
    run_op("divu x/0",    2'b01, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1'b1, LZ);
    run_op("remu x/0",    2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678,  1'b1, LZ);
    run_op("div ovf",     2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, LZ);
    run_op("rem ovf",     2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b0, LZ);
    run_op("div 7/-2",    2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, LAT);
    run_op("rem 7/-2",    2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, LAT);
    run_op("div -7/0",    2'b00, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1'b1, LZ);
    run_op("rem -7/0",    2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b1, LZ);
    run_op("divu max/1",  2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, LAT);

    // Back-to-back: new request raised while done is high.
    run_op("b2b first",   2'b01, 32'd100,        32'd7,          32'd14,         1'b0, LAT);
    start(2'b01, 32'd81, 32'd9);
    wait_done("b2b second", 32'd9, 1'b0, LAT);

    // Reset mid-operation with an ignored second request.
    @(negedge CLK);
    start(2'b01, 32'd1000, 32'd10);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    En    = 1'b1;
    funct = 2'b00;
    rs_1  = 32'd5;
    rs_2  = 32'd1;
    @(posedge CLK);
    #1 En = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("busy mid-op", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rst busy",   {31'b0, busy},        32'd0);
    check("async rst done",   {31'b0, done},        32'd0);
    check("async rst result", result,               32'd0);
    check("async rst dbz",    {31'b0, div_by_zero}, 32'd0);
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    n = 0;
    repeat (45) begin
      @(negedge CLK);
      if (done === 1'b1) n++;
    end
    check("no done after reset", n, 32'd0);

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/int_div_unit.md
INT_DIV_UNIT -- requirements
Module: int_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have port CLK  in  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port En  in  1  start request, sampled only while busy=0.
REQ-005 SHALL have port funct  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port rs_1  in  WIDTH  dividend.
REQ-007 SHALL have port rs_2  in  WIDTH  divisor.
REQ-008 SHALL have port busy  out  1  high while an operation is in flight.
REQ-009 SHALL have port done  out  1  one-cycle pulse, result valid.
REQ-010 SHALL have port result  out  WIDTH  quotient or remainder per funct, held until next done.
REQ-011 SHALL have port div_by_zero  out  1  rs_2 was zero, valid with done, held with result.

Function
REQ-012 SHALL implement FSM IDLE, CALC, FIX; busy = (state != IDLE).
REQ-013 SHALL, in IDLE with En=1, latch funct, |rs_1|, |rs_2| (magnitudes for signed ops), operand signs, and enter CALC with iteration counter WIDTH-1.
REQ-014 SHALL ignore En while busy=1; operand changes after the start edge SHALL have no effect.
REQ-015 SHALL, in CALC, perform one restoring-division step per cycle: shift {rem,quot} left, trial-subtract divisor from rem, keep difference and set quotient bit 1 when no borrow, else restore and set 0.
REQ-016 SHALL leave CALC for FIX after exactly WIDTH steps (counter reaching 0).
REQ-017 SHALL, in FIX, apply sign correction (quotient negated when operand signs differ, remainder takes dividend sign), register result, div_by_zero, pulse done=1, and return to IDLE.
REQ-018 SHALL assert done exactly WIDTH+1 rising edges after the start edge on the iterative path (33 for WIDTH=32).
REQ-019 SHALL accept En in the same cycle done is high (back-to-back, no bubble).
REQ-020 SHALL return for divide by zero: quotient all ones, remainder = rs_1, div_by_zero=1.
REQ-021 SHALL return for signed overflow (DIV/REM, rs_1=most-negative, rs_2=all ones): quotient = rs_1, remainder 0.
REQ-022 SHALL size the remainder datapath WIDTH+1 bits so no shifted remainder is truncated.

Reset
REQ-023 SHALL on rst_n=0, immediately and regardless of state, force state IDLE, busy=0, done=0, result=0, div_by_zero=0, counter and internal registers 0.
REQ-024 SHALL, if reset occurs mid-operation, discard the operation; no done pulse after reset release.

Configuration
REQ-025 SHALL support macro DIV_EARLY_OUT_EN.
REQ-026 With DIV_EARLY_OUT_EN defined: divide-by-zero and signed-overflow cases SHALL skip CALC (IDLE->FIX), done asserted 1 edge after start edge.
REQ-027 Without DIV_EARLY_OUT_EN: all operations SHALL take the CALC path with REQ-018 latency; results per REQ-020/021 unchanged.

Structure
REQ-028 SHALL place state encoding, funct encodings (DIV/DIVU/REM/REMU) and default WIDTH in shared package div_pkg.
REQ-029 SHALL instantiate the existing CLA_ADD_SUB as sole sub-module for the trial subtraction (WIDTH+1, En=1, SUB=1), borrow taken from its overflow output.

Verification
REQ-030 DIVU rs_1=100 rs_2=7 -> result 14, done at edge 33; REMU same operands -> 2.
REQ-031 DIV rs_1=0xFFFFFFEC(-20) rs_2=3 -> 0xFFFFFFFA(-6); REM -> 0xFFFFFFFE(-2).
REQ-032 DIVU rs_1=0x12345678 rs_2=0 -> 0xFFFFFFFF, div_by_zero=1; REMU -> 0x12345678; done at edge 1 with DIV_EARLY_OUT_EN, edge 33 without.
REQ-033 DIV rs_1=0x80000000 rs_2=0xFFFFFFFF -> 0x80000000; REM -> 0, div_by_zero=0.
REQ-034 Start DIVU 1000/10, pulse En with other operands at cycle 5, assert rst_n=0 at cycle 10 -> busy, done, result, div_by_zero immediately 0, no done afterwards; second En ignored before reset.
REQ-035 Raise En with DIVU 81/9 during done cycle of a prior op -> accepted, result 9 with done 33 edges later.
